// File: rtl/mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mio_bus_arbiter
//
// Shares a single memory port between the multi-cycle CPU controller and a
// DMA/VGA requester. One requester is granted at a time. The granted request's
// write enable, address and write data are latched into the memory-port
// registers, a single mem_en strobe is issued, the memory latency is counted
// down, and completion is reported with a one-cycle pulse (MIO_ready for the
// CPU, dma_ack for DMA). Read data is captured into a per-requester register.
//
// Parameters
//   ADDR_W   address width of both requesters and the memory port
//   DATA_W   data width
//   MEM_LAT  memory read latency in cycles (>= 1); ACCESS lasts this long
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request, held until MIO_ready
//   cpu_rdata, MIO_ready        CPU read data (registered) and completion pulse
//   dma_req/we/addr/wdata       DMA request, held until dma_ack
//   dma_rdata, dma_ack          DMA read data (registered) and completion pulse
//   mem_en                      one-cycle strobe at the start of each access
//   mem_we/addr/wdata           held for the whole access
//   mem_rdata                   memory read data, sampled at the end of ACCESS
//   grant_dma                   0 = CPU owns the bus, 1 = DMA owns the bus
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: ties go to the requester not granted last.
//                       undefined: fixed priority, CPU wins every tie.
//
// States
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | sample requests, pick a winner, latch its request
//   ST_ACCESS | memory access in flight, MEM_LAT cycles, mem_en in first only
//   ST_DONE   | read data captured, winner's completion pulse high
// -----------------------------------------------------------------------------
module mio_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              MIO_ready,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              grant_dma
);

  // Counter holds cycles remaining in ACCESS; it is reloaded in IDLE and only
  // counts down to zero, so it never wraps.
  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              mem_en_nxt;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              grant_dma_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt;
  logic [DATA_W-1:0] dma_rdata_nxt;
  logic              mio_ready_nxt;
  logic              dma_ack_nxt;

  logic              any_req;
  logic              pick_dma;

  assign any_req = cpu_req | dma_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Tie-break pointer: names the requester that wins the next tie. Starting
  // at CPU and flipping to the loser of every grant means a tie always goes
  // to whoever was not granted last.
  logic rr_dma, rr_dma_nxt;

  assign pick_dma = dma_req & (~cpu_req | rr_dma);
`else
  assign pick_dma = dma_req & ~cpu_req;
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_dma <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      MIO_ready <= 1'b0;
      dma_ack   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_dma    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      grant_dma <= grant_dma_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      dma_rdata <= dma_rdata_nxt;
      MIO_ready <= mio_ready_nxt;
      dma_ack   <= dma_ack_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      rr_dma    <= rr_dma_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    grant_dma_nxt = grant_dma;
    cpu_rdata_nxt = cpu_rdata;
    dma_rdata_nxt = dma_rdata;
    mio_ready_nxt = 1'b0;
    dma_ack_nxt   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_dma_nxt    = rr_dma;
`endif

    case (state)
      ST_IDLE: begin
        cnt_nxt = CNT_LOAD;
        if (any_req) begin
          state_nxt     = ST_ACCESS;
          mem_en_nxt    = 1'b1;
          grant_dma_nxt = pick_dma;
          if (pick_dma) begin
            mem_we_nxt    = dma_we;
            mem_addr_nxt  = dma_addr;
            mem_wdata_nxt = dma_wdata;
          end else begin
            mem_we_nxt    = cpu_we;
            mem_addr_nxt  = cpu_addr;
            mem_wdata_nxt = cpu_wdata;
          end
`ifdef ARB_ROUND_ROBIN_EN
          rr_dma_nxt = ~pick_dma;
`endif
        end
      end

      ST_ACCESS: begin
        if (cnt == '0) begin
          // Last ACCESS cycle: memory data is valid now, so it is captured on
          // the same edge that raises the completion pulse.
          state_nxt = ST_DONE;
          if (!mem_we) begin
            if (grant_dma) begin
              dma_rdata_nxt = mem_rdata;
            end else begin
              cpu_rdata_nxt = mem_rdata;
            end
          end
          mio_ready_nxt = ~grant_dma;
          dma_ack_nxt   = grant_dma;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      ST_DONE: begin
        // Always return to IDLE so a request still held here is re-sampled
        // instead of being issued twice.
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_arbiter
//
// Self-checking bench for mio_bus_arbiter. The main instance uses MEM_LAT=2;
// a second instance with MEM_LAT=1 covers the short-latency back-to-back case.
// Expected values come from a transaction-level model: the arbitration rule,
// the cycle timeline of a transaction, and a memory content function.
// -----------------------------------------------------------------------------
module tb_mio_bus_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;

  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        MIO_ready;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        grant_dma;

  // second instance, MEM_LAT = 1, CPU side only
  logic        c2_cpu_req, c2_cpu_we;
  logic [31:0] c2_cpu_addr, c2_cpu_wdata, c2_cpu_rdata;
  logic        c2_ready;
  logic        c2_dma_req, c2_dma_we;
  logic [31:0] c2_dma_addr, c2_dma_wdata, c2_dma_rdata;
  logic        c2_dma_ack;
  logic        c2_mem_en, c2_mem_we;
  logic [31:0] c2_mem_addr, c2_mem_wdata, c2_mem_rdata;
  logic        c2_grant_dma;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  bit          m_last_dma;   // who was granted last; 1 after reset so CPU takes the first tie
  logic [31:0] m_cpu_rd, m_dma_rd;

  always #5 clk = ~clk;

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_dma(grant_dma)
  );

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(c2_cpu_req), .cpu_we(c2_cpu_we), .cpu_addr(c2_cpu_addr), .cpu_wdata(c2_cpu_wdata),
    .cpu_rdata(c2_cpu_rdata), .MIO_ready(c2_ready),
    .dma_req(c2_dma_req), .dma_we(c2_dma_we), .dma_addr(c2_dma_addr), .dma_wdata(c2_dma_wdata),
    .dma_rdata(c2_dma_rdata), .dma_ack(c2_dma_ack),
    .mem_en(c2_mem_en), .mem_we(c2_mem_we), .mem_addr(c2_mem_addr), .mem_wdata(c2_mem_wdata),
    .mem_rdata(c2_mem_rdata), .grant_dma(c2_grant_dma)
  );

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hC35A, a[31:16] ^ 16'h1F2E};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
  endtask

  task automatic model_reset();
    m_last_dma = 1'b1;
    m_cpu_rd   = '0;
    m_dma_rd   = '0;
  endtask

  task automatic scramble_inputs();
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    dma_req   = 1'($urandom_range(0, 1));
    dma_we    = 1'($urandom_range(0, 1));
    dma_addr  = $urandom;
    dma_wdata = $urandom;
  endtask

  // Drive one request set while the arbiter is idle and follow the whole
  // transaction: ACCESS cycles, DONE, and the return to IDLE.
  task automatic do_txn(input bit c_req, input bit c_we, input logic [31:0] c_addr,
                        input logic [31:0] c_wd, input bit d_req, input bit d_we,
                        input logic [31:0] d_addr, input logic [31:0] d_wd,
                        output logic obs_grant);
    bit          w;
    logic        e_we;
    logic [31:0] e_addr, e_wd;

    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
    mem_rdata = $urandom;

`ifdef ARB_ROUND_ROBIN_EN
    if (c_req && d_req) w = !m_last_dma;
    else                w = d_req;
`else
    w = d_req && !c_req;
`endif
    m_last_dma = w;
    e_we   = w ? d_we   : c_we;
    e_addr = w ? d_addr : c_addr;
    e_wd   = w ? d_wd   : c_wd;

    tick();
    obs_grant = grant_dma;
    for (int k = 1; k <= LAT; k++) begin
      chk("acc_mem_en",    mem_en,    (k == 1));
      chk("acc_mem_we",    mem_we,    e_we);
      chk("acc_mem_addr",  mem_addr,  e_addr);
      chk("acc_mem_wdata", mem_wdata, e_wd);
      chk("acc_grant",     grant_dma, w);
      chk("acc_ready",     MIO_ready, 1'b0);
      chk("acc_ack",       dma_ack,   1'b0);
      scramble_inputs();
      mem_rdata = (k == LAT) ? rd_val(e_addr) : $urandom;
      tick();
    end

    if (!e_we) begin
      if (w) m_dma_rd = rd_val(e_addr);
      else   m_cpu_rd = rd_val(e_addr);
    end
    chk("done_ready",     MIO_ready, !w);
    chk("done_ack",       dma_ack,   w);
    chk("done_mem_en",    mem_en,    1'b0);
    chk("done_cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("done_dma_rdata", dma_rdata, m_dma_rd);
    scramble_inputs();
    mem_rdata = $urandom;
    tick();

    chk("idle_ready",  MIO_ready, 1'b0);
    chk("idle_ack",    dma_ack,   1'b0);
    chk("idle_mem_en", mem_en,    1'b0);
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       g;
    logic [3:0] t4_order;
    int         n_en, n_rdy, rdy_cyc;

`ifdef ARB_ROUND_ROBIN_EN
    t4_order = 4'b1010;
`else
    t4_order = 4'b0000;
`endif

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
    c2_cpu_req = 1'b0; c2_cpu_we = 1'b0; c2_cpu_addr = '0; c2_cpu_wdata = '0;
    c2_dma_req = 1'b0; c2_dma_we = 1'b0; c2_dma_addr = '0; c2_dma_wdata = '0;
    c2_mem_rdata = '0;
    reset = 1'b1;
    model_reset();

    // T1: reset held two cycles with both requests high
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_mem_en",    mem_en,    1'b0);
      chk("rst_mem_we",    mem_we,    1'b0);
      chk("rst_mem_addr",  mem_addr,  32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("rst_dma_rdata", dma_rdata, 32'h0);
      chk("rst_ready",     MIO_ready, 1'b0);
      chk("rst_ack",       dma_ack,   1'b0);
      chk("rst_grant",     grant_dma, 1'b0);
    end
    chk("rst_lat1_mem_en", c2_mem_en, 1'b0);
    chk("rst_lat1_rdata",  c2_cpu_rdata, 32'h0);
    reset = 1'b0;

    // T4: both requests held for four transactions right after reset
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0,
             1'b1, 1'b0, 32'h3000 + 32'(i * 4), 32'h0, g);
      chk("t4_order", g, t4_order[i]);
    end

    // T2: CPU read of 0x10
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);
    chk("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // T3: DMA write of 0x1234 to 0x2000
    do_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h1234, g);
    chk("t3_grant", g, 1'b1);

    // T5: reset in the second ACCESS cycle of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; dma_req = 1'b0;
    tick();
    chk("t5_mem_en", mem_en, 1'b1);
    tick();
    reset = 1'b1;
    mem_rdata = rd_val(32'h30);
    tick();
    chk("t5_no_ready", MIO_ready, 1'b0);
    chk("t5_cpu_rdata", cpu_rdata, 32'h0);
    chk("t5_mem_en_off", mem_en, 1'b0);
    reset = 1'b0;
    model_reset();
    // arbiter must be idle now, so the next request is granted on the next edge
    do_txn(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g);

    // Randomized traffic with idle gaps
    for (int i = 0; i < 40; i++) begin
      int gap;
      int r;
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        chk("gap_mem_en", mem_en, 1'b0);
        chk("gap_ready",  MIO_ready, 1'b0);
        chk("gap_ack",    dma_ack, 1'b0);
      end
      r = $urandom_range(1, 3);
      do_txn(r[0], 1'($urandom_range(0, 1)), $urandom, $urandom,
             r[1], 1'($urandom_range(0, 1)), $urandom, $urandom, g);
    end

    // T6: MEM_LAT=1, CPU holds its request through DONE, then drops it
    c2_cpu_req = 1'b1; c2_cpu_we = 1'b0; c2_cpu_addr = 32'h44;
    c2_mem_rdata = rd_val(32'h44);
    n_en = 0; n_rdy = 0; rdy_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c2_mem_en) n_en++;
      if (c2_ready) begin
        n_rdy++;
        rdy_cyc = c;
      end
      if (c == 3) c2_cpu_req = 1'b0;
    end
    chk("t6_mem_en_count", 64'(n_en), 64'd1);
    chk("t6_ready_count",  64'(n_rdy), 64'd1);
    chk("t6_ready_cycle",  64'(rdy_cyc), 64'd2);
    chk("t6_cpu_rdata",    c2_cpu_rdata, rd_val(32'h44));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
